// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer. It steps through one 10-state FSM and drives
// the datapath enables and mux selects for R-type, lw, sw, beq and j.
// Memory accesses in FETCH, MEMRD and MEMWR stall until mem_ready is high.
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    state_t state_q;
    state_t state_d;

    assign state = state_q;

    // State register. This is the only storage in the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and Moore/Mealy outputs. While rst is held, every output is forced to zero.
    always_comb begin
        state_d     = S_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;

        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    // Read the instruction at PC and compute PC+4 in the same cycle.
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                    state_d = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    // Compute the branch target early, while the opcode is being decoded.
                    ALUSrcB = 2'b11;
                    if (Opcode == OP_LW || Opcode == OP_SW) begin
                        state_d = S_MEMADR;
                    end else if (Opcode == OP_RTYPE) begin
                        state_d = S_EXEC;
                    end else if (Opcode == OP_BEQ) begin
                        state_d = S_BEQ;
                    end else if (Opcode == OP_J) begin
                        state_d = S_JUMP;
                    end else begin
                        // PC is already advanced, so this instruction ends here.
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    if (Opcode == OP_LW) begin
                        state_d = S_MEMRD;
                    end else if (Opcode == OP_SW) begin
                        state_d = S_MEMWR;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    state_d = mem_ready ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    MemtoReg   = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMWR: begin
                    // Hold the write request until memory accepts it.
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = mem_ready;
                    state_d    = mem_ready ? S_FETCH : S_MEMWR;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                    state_d = S_RWB;
                end
                S_RWB: begin
                    RegDst     = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_BEQ: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    instr_done  = 1'b1;
                    state_d     = S_FETCH;
                end
                S_JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b10;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                default: begin
                    // Encodings 10-15: recover to FETCH with every output low.
                    state_d = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: it walks each instruction class
// cycle by cycle and compares state and the packed control outputs.
module tb_multicycle_control;

    logic       clk;
    logic       rst;
    logic [5:0] Opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    multicycle_control dut (
        .clk         (clk),
        .rst         (rst),
        .Opcode      (Opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field order: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
    // MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB[2], ALUOp[2], PCSource[2],
    // instr_done, illegal_op.
    logic [17:0] outs;
    assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                   PCSource, instr_done, illegal_op};

    localparam logic [17:0] E_ZERO       = 18'd0;
    localparam logic [17:0] E_FETCH_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_FETCH_RDY  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_DEC_ILL    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1,1'b1};
    localparam logic [17:0] E_MEMADR     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_MEMRD      = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_MEMWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
    localparam logic [17:0] E_MW_WAIT    = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_MW_RDY     = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
    localparam logic [17:0] E_EXEC       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_RWB        = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
    localparam logic [17:0] E_BEQ        = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0};
    localparam logic [17:0] E_JUMP       = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b1,1'b0};

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst       = 1'b1;
        mem_ready = 1'b1;
        Opcode    = 6'b000000;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (state !== 4'd0) begin
            failures++;
            $display("FAIL reset_state: got %0d expected 0", state);
        end
        checks++;
        if (outs !== E_ZERO) begin
            failures++;
            $display("FAIL reset_outs: got %b expected %b", outs, E_ZERO);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_rtype();
        logic [3:0]  st [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
        logic [17:0] ex [4] = '{E_FETCH_RDY, E_DECODE, E_EXEC, E_RWB};
        Opcode = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            #1;
            checks++;
            if (state !== st[i]) begin
                failures++;
                $display("FAIL rtype_state cyc%0d: got %0d expected %0d", i, state, st[i]);
            end
            checks++;
            if (outs !== ex[i]) begin
                failures++;
                $display("FAIL rtype_outs cyc%0d: got %b expected %b", i, outs, ex[i]);
            end
            @(negedge clk);
        end
        $display("rtype done: 4 cycles");
    endtask

    task automatic test_lw_stall();
        logic        mr [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0]  st [10] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
        logic [17:0] ex [10] = '{E_FETCH_WAIT, E_FETCH_WAIT, E_FETCH_RDY, E_DECODE, E_MEMADR,
                                 E_MEMRD, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMWB};
        Opcode = 6'b100011;
        for (int i = 0; i < 10; i++) begin
            mem_ready = mr[i];
            #1;
            checks++;
            if (state !== st[i]) begin
                failures++;
                $display("FAIL lw_state cyc%0d: got %0d expected %0d", i, state, st[i]);
            end
            checks++;
            if (outs !== ex[i]) begin
                failures++;
                $display("FAIL lw_outs cyc%0d: got %b expected %b", i, outs, ex[i]);
            end
            @(negedge clk);
        end
        $display("lw with stalls done: 10 cycles");
    endtask

    task automatic test_sw();
        // First store has no stall; the second one waits one cycle in MEMWR.
        logic        mr [9] = '{1'b1, 1'b1, 1'b1, 1'b1,
                                1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0]  st [9] = '{4'd0, 4'd1, 4'd2, 4'd5,
                                4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
        logic [17:0] ex [9] = '{E_FETCH_RDY, E_DECODE, E_MEMADR, E_MW_RDY,
                                E_FETCH_RDY, E_DECODE, E_MEMADR, E_MW_WAIT, E_MW_RDY};
        Opcode = 6'b101011;
        for (int i = 0; i < 9; i++) begin
            mem_ready = mr[i];
            #1;
            checks++;
            if (state !== st[i]) begin
                failures++;
                $display("FAIL sw_state cyc%0d: got %0d expected %0d", i, state, st[i]);
            end
            checks++;
            if (outs !== ex[i]) begin
                failures++;
                $display("FAIL sw_outs cyc%0d: got %b expected %b", i, outs, ex[i]);
            end
            @(negedge clk);
        end
        $display("sw x2 done: 4 + 5 cycles");
    endtask

    task automatic test_beq_j();
        logic [5:0]  op [6] = '{6'b000100, 6'b000100, 6'b000100,
                                6'b000010, 6'b000010, 6'b000010};
        logic [3:0]  st [6] = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9};
        logic [17:0] ex [6] = '{E_FETCH_RDY, E_DECODE, E_BEQ,
                                E_FETCH_RDY, E_DECODE, E_JUMP};
        for (int i = 0; i < 6; i++) begin
            Opcode    = op[i];
            mem_ready = 1'b1;
            #1;
            checks++;
            if (state !== st[i]) begin
                failures++;
                $display("FAIL beqj_state cyc%0d: got %0d expected %0d", i, state, st[i]);
            end
            checks++;
            if (outs !== ex[i]) begin
                failures++;
                $display("FAIL beqj_outs cyc%0d: got %b expected %b", i, outs, ex[i]);
            end
            @(negedge clk);
        end
        $display("beq then j done: 3 + 3 cycles");
    endtask

    task automatic test_illegal();
        logic [3:0]  st [2] = '{4'd0, 4'd1};
        logic [17:0] ex [2] = '{E_FETCH_RDY, E_DEC_ILL};
        Opcode = 6'b001000;
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'b1;
            #1;
            checks++;
            if (state !== st[i]) begin
                failures++;
                $display("FAIL illegal_state cyc%0d: got %0d expected %0d", i, state, st[i]);
            end
            checks++;
            if (outs !== ex[i]) begin
                failures++;
                $display("FAIL illegal_outs cyc%0d: got %b expected %b", i, outs, ex[i]);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (state !== 4'd0) begin
            failures++;
            $display("FAIL illegal_return: got %0d expected 0", state);
        end
        $display("illegal opcode done: 2 cycles");
    endtask

    task automatic test_reset_mid();
        logic        mr_a [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0]  st_a [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
        logic [17:0] ex_a [4] = '{E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMRD};
        logic [3:0]  st_b [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        logic [17:0] ex_b [5] = '{E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB};
        Opcode = 6'b100011;
        for (int i = 0; i < 4; i++) begin
            mem_ready = mr_a[i];
            #1;
            checks++;
            if (state !== st_a[i] || outs !== ex_a[i]) begin
                failures++;
                $display("FAIL rstmid_pre cyc%0d: got state=%0d outs=%b expected state=%0d outs=%b",
                         i, state, outs, st_a[i], ex_a[i]);
            end
            @(negedge clk);
        end
        // Still in MEMRD waiting on memory; pulse reset between clock edges.
        mem_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0) begin
            failures++;
            $display("FAIL rstmid_async_state: got %0d expected 0", state);
        end
        checks++;
        if (outs !== E_ZERO) begin
            failures++;
            $display("FAIL rstmid_async_outs: got %b expected %b", outs, E_ZERO);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (state !== 4'd0 || outs !== E_ZERO) begin
            failures++;
            $display("FAIL rstmid_held: got state=%0d outs=%b expected state=0 outs=%b",
                     state, outs, E_ZERO);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'b1;
            #1;
            checks++;
            if (state !== st_b[i] || outs !== ex_b[i]) begin
                failures++;
                $display("FAIL rstmid_post cyc%0d: got state=%0d outs=%b expected state=%0d outs=%b",
                         i, state, outs, st_b[i], ex_b[i]);
            end
            @(negedge clk);
        end
        $display("reset mid-MEMRD done: aborted and restarted cleanly");
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        Opcode    = 6'b000000;
        test_reset();
        test_rtype();
        test_lw_stall();
        test_sw();
        test_beq_j();
        test_illegal();
        test_reset_mid();
        #1;
        checks++;
        if (state !== 4'd0) begin
            failures++;
            $display("FAIL final_state: got %0d expected 0", state);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS core: one shared ALU and one unified instruction/data memory, reused across several cycles per instruction.
- Decodes the IR opcode and walks a 10-state FSM.
- Emits per-cycle datapath enables and mux selects.
- Stalls on a memory ready handshake.
- Supports R-type, lw, sw, beq and j; any other opcode is flagged illegal and skipped.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-if-equal opcode
- OP_J, 6'b000010, jump opcode

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- Opcode  input  6  IR[31:26]; stable from DECODE onward
- mem_ready  input  1  memory has completed the current read/write this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load qualified by ALU Zero (beq)
- IorD  output  1  memory address select: 0=PC, 1=ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  writeback select: 0=ALUOut, 1=MDR
- RegDst  output  1  destination register select: 0=rt, 1=rd
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  ALU A select: 0=PC, 1=A reg
- ALUSrcB  output  2  ALU B select: 00=B reg, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- ALUOp  output  2  00=add, 01=sub, 10=funct decode
- PCSource  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
- instr_done  output  1  one-cycle pulse on an instruction's final cycle
- illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode
- state  output  4  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BEQ=8, JUMP=9.
- Encodings 10-15 are unreachable. If entered, next state is FETCH and all outputs are 0.
- The state register is the only storage. Outputs are combinational from state, Opcode and mem_ready.
- Any output not listed for a state is 0.
- Reset: rst high forces state=FETCH asynchronously.
- While rst is high, every output is 0 except state=0; this overrides the FETCH decode.
- After rst is released, the first FETCH cycle starts on the next rising edge.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Next state: DECODE if mem_ready, else stay in FETCH.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precompute branch target).
  - Next state by Opcode: lw/sw -> MEMADR, R-type -> EXEC, beq -> BEQ, j -> JUMP.
  - Any other Opcode: illegal_op=1, instr_done=1, next FETCH; PC is already advanced.
- MEMADR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state: MEMRD if Opcode=lw, MEMWR if Opcode=sw.
- MEMRD:
  - Outputs: MemRead=1, IorD=1.
  - Next state: MEMWB if mem_ready, else stay.
- MEMWB:
  - Outputs: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1.
  - Next state: FETCH.
- MEMWR:
  - Outputs: MemWrite=1, IorD=1; MemWrite is held until mem_ready.
  - instr_done=mem_ready.
  - Next state: FETCH if mem_ready, else stay.
- EXEC:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Next state: RWB.
- RWB:
  - Outputs: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1.
  - Next state: FETCH.
- BEQ:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1.
  - Next state: FETCH.
- JUMP:
  - Outputs: PCWrite=1, PCSource=10, instr_done=1.
  - Next state: FETCH.
- Latency with mem_ready tied to 1:
  - R-type 4 cycles, lw 5, sw 4, beq 3, j 3, illegal 2.
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in all other states.
- MemRead and MemWrite are never asserted together.
- RegWrite, PCWrite and IRWrite are never asserted in the same cycle as MemWrite.
- Reset mid-instruction: the FSM aborts immediately; no further write enables are issued and no instr_done is pulsed.

Test Plan:
- Reset, then Opcode=000000 with mem_ready=1 -> states 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; instr_done pulses once, on cycle 4.
- lw (100011), mem_ready low for 2 cycles in FETCH and 3 cycles in MEMRD -> 10 cycles total; IRWrite=PCWrite=1 only on the FETCH cycle with mem_ready=1; MemtoReg=1 and RegWrite=1 in MEMWB.
- sw (101011), mem_ready=1 -> states 0,1,2,5,0; MemWrite=1 and IorD=1 in state 5 only; RegWrite never asserted.
- beq (000100) followed by j (000010) -> 3 cycles each; PCWriteCond=1 with PCSource=01 and ALUOp=01 in BEQ; PCWrite=1 with PCSource=10 in JUMP.
- Opcode=001000 (unsupported) -> illegal_op=1 and instr_done=1 in DECODE, then FETCH; no RegWrite or MemWrite asserted.
- Assert rst asynchronously mid-cycle in MEMRD -> state=0 and all outputs 0 immediately, without waiting for a clock edge; after release the next edge begins a normal FETCH.
